conv_encoder: RTL

Convolutional encoder that is the transmit-side counterpart of `viterbi_core`. It reads packed information bits from an info buffer and encodes them with the same `register_num_i`, `polynomial*_i`, `valid_polynomials_i` and `tail_biting_en_i` semantics the decoder uses. For every trellis step it writes one 24-bit soft-bit word into the decoder's input SRAM. This lets the same frame be produced on chip and decoded back for loopback and self-test.

---
 rtl/conv_encoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// Convolutional encoder: reads packed info bits, writes one 24-bit soft-bit word per trellis step.
// Supports memory depth 3..6, up to six generator polynomials, zero-tail or tail-biting frames.
module conv_encoder #(
  parameter int unsigned SRC_ADDR_W = 12,
  parameter int unsigned DST_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic [1:0]            register_num_i,
  input  logic [2:0]            valid_polynomials_i,
  input  logic                  tail_biting_en_i,
  input  logic [7:0]            polynomial1_i,
  input  logic [7:0]            polynomial2_i,
  input  logic [7:0]            polynomial3_i,
  input  logic [7:0]            polynomial4_i,
  input  logic [7:0]            polynomial5_i,
  input  logic [7:0]            polynomial6_i,
  input  logic [11:0]           infobit_length_i,
  input  logic [SRC_ADDR_W-1:0] src_start_addr_i,
  input  logic [DST_ADDR_W-1:0] dst_start_addr_i,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  src_rd_o,
  output logic [SRC_ADDR_W-1:0] src_addr_o,
  input  logic [7:0]            src_rdata_i,
  output logic                  dst_wr_o,
  output logic [DST_ADDR_W-1:0] dst_addr_o,
  output logic [23:0]           dst_wdata_o
);

  typedef enum logic [2:0] {
    StIdle, StPreRd, StPreLd, StRd, StLd, StEmit, StTail, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            s_q, s_d;
  logic [2:0]            m_q, m_d;
  logic [2:0]            vp_q, vp_d;
  logic                  tb_q, tb_d;
  logic [5:0][7:0]       poly_q, poly_d;
  logic [11:0]           len_q, len_d;
  logic [SRC_ADDR_W-1:0] src_base_q, src_base_d;
  logic [DST_ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [8:0]            byte_idx_q, byte_idx_d;
  logic [12:0]           word_idx_q, word_idx_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]            tail_cnt_q, tail_cnt_d;
  logic [7:0]            data_q, data_d;
  logic [7:0]            hi_byte_q, hi_byte_d;
  logic                  pre_second_q, pre_second_d;

  logic [11:0] len_m1, len_m1_in;
  logic [8:0]  last_byte;
  logic [2:0]  nb_m1;
  logic [2:0]  m_in;
  logic [7:0]  mask_in;
  logic        u;
  logic [7:0]  tap_vec;
  logic [5:0]  coded;
  logic [23:0] wdata;
  logic [15:0] win;
  logic [3:0]  pos;
  logic [5:0]  s_load;

  assign len_m1    = len_q - 12'd1;
  assign len_m1_in = infobit_length_i - 12'd1;
  assign last_byte = len_m1[11:3];
  // Index of the final bit in the current byte: partial only for the last byte.
  assign nb_m1     = (byte_idx_q == last_byte) ? len_m1[2:0] : 3'd7;
  assign m_in      = 3'd6 - {1'b0, register_num_i};
  assign mask_in   = 8'hFF >> (3'd7 - m_in);
  assign u         = (state_q == StEmit) ? data_q[bit_cnt_q] : 1'b0;
  assign tap_vec   = {1'b0, s_q, u};

  always_comb begin
    wdata = '0;
    coded = '0;
    for (int j = 0; j < 6; j++) begin
      coded[j] = ^(poly_q[j] & tap_vec);
      if (3'(j) <= vp_q) begin
        wdata[4*j +: 4] = coded[j] ? 4'h9 : 4'h7;
      end
    end
  end

  // Tail-biting start state: window holds bytes hi and hi-1 (or byte 0 alone, shifted up).
  always_comb begin
    win    = pre_second_q ? {hi_byte_q, src_rdata_i} : {src_rdata_i, 8'h00};
    s_load = '0;
    pos    = '0;
    for (int k = 1; k <= 6; k++) begin
      pos = {1'b0, len_m1[2:0]} + 4'd9 - 4'(k);
      if (3'(k) <= m_q) begin
        s_load[k-1] = win[pos];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    m_d          = m_q;
    vp_d         = vp_q;
    tb_d         = tb_q;
    poly_d       = poly_q;
    len_d        = len_q;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    bit_cnt_d    = bit_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    data_d       = data_q;
    hi_byte_d    = hi_byte_q;
    pre_second_d = pre_second_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          m_d          = m_in;
          vp_d         = (valid_polynomials_i > 3'd5) ? 3'd5 : valid_polynomials_i;
          tb_d         = tail_biting_en_i;
          poly_d[0]    = polynomial1_i & mask_in;
          poly_d[1]    = polynomial2_i & mask_in;
          poly_d[2]    = polynomial3_i & mask_in;
          poly_d[3]    = polynomial4_i & mask_in;
          poly_d[4]    = polynomial5_i & mask_in;
          poly_d[5]    = polynomial6_i & mask_in;
          len_d        = infobit_length_i;
          src_base_d   = src_start_addr_i;
          dst_base_d   = dst_start_addr_i;
          s_d          = '0;
          word_idx_d   = '0;
          bit_cnt_d    = '0;
          tail_cnt_d   = '0;
          pre_second_d = 1'b0;
          if (tail_biting_en_i) begin
            byte_idx_d = len_m1_in[11:3];
            state_d    = StPreRd;
          end else begin
            byte_idx_d = '0;
            state_d    = StRd;
          end
        end
      end
      StPreRd: state_d = StPreLd;
      StPreLd: begin
        if (!pre_second_q && (last_byte != 9'd0)) begin
          hi_byte_d    = src_rdata_i;
          byte_idx_d   = last_byte - 9'd1;
          pre_second_d = 1'b1;
          state_d      = StPreRd;
        end else begin
          s_d        = s_load;
          byte_idx_d = '0;
          state_d    = StRd;
        end
      end
      StRd: state_d = StLd;
      StLd: begin
        data_d  = src_rdata_i;
        state_d = StEmit;
      end
      StEmit: begin
        s_d        = {s_q[4:0], u};
        word_idx_d = word_idx_q + 13'd1;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == nb_m1) begin
          bit_cnt_d = '0;
          if (byte_idx_q == last_byte) begin
            state_d = tb_q ? StDone : StTail;
          end else begin
            byte_idx_d = byte_idx_q + 9'd1;
            state_d    = StRd;
          end
        end
      end
      StTail: begin
        s_d        = {s_q[4:0], 1'b0};
        word_idx_d = word_idx_q + 13'd1;
        tail_cnt_d = tail_cnt_q + 3'd1;
        if (tail_cnt_q == m_q - 3'd1) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      s_q          <= '0;
      m_q          <= '0;
      vp_q         <= '0;
      tb_q         <= 1'b0;
      poly_q       <= '0;
      len_q        <= '0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      bit_cnt_q    <= '0;
      tail_cnt_q   <= '0;
      data_q       <= '0;
      hi_byte_q    <= '0;
      pre_second_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      m_q          <= m_d;
      vp_q         <= vp_d;
      tb_q         <= tb_d;
      poly_q       <= poly_d;
      len_q        <= len_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      data_q       <= data_d;
      hi_byte_q    <= hi_byte_d;
      pre_second_q <= pre_second_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = (state_q == StDone);
  assign src_rd_o     = (state_q == StPreRd) || (state_q == StRd);
  assign dst_wr_o     = (state_q == StEmit) || (state_q == StTail);
  assign src_addr_o   = src_base_q + SRC_ADDR_W'(byte_idx_q);
  assign dst_addr_o   = dst_base_q + DST_ADDR_W'(word_idx_q);
  assign dst_wdata_o  = dst_wr_o ? wdata : 24'h0;

endmodule
